// File: rtl/pipe_drain.sv
// Output collector for the scaling pipe stage: realigns pair validity, buffers pairs in a FWFT FIFO.
// Optional running XOR checksum of accepted words, built when PIPE_DRAIN_CKSUM_EN is defined.
module pipe_drain #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_en_tap,
  input  logic [15:0]              i_data0,
  input  logic [15:0]              i_data1,
  output logic [31:0]              o_data,
  output logic                     o_vld,
  input  logic                     i_rdy,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_ovf,
  output logic [7:0]               o_drop_cnt,
  output logic [31:0]              o_cksum
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic          r_en_d1;
  logic          r_en_d2;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [31:0]   r_mem [DEPTH];
  logic          r_ovf;
  logic [7:0]    r_drop_cnt;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [31:0]   w_word;

  assign w_word  = {i_data1, i_data0};
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && i_rdy;
  // A full FIFO still accepts a pair when the head leaves on the same edge.
  assign w_push  = r_en_d2 && (!w_full || w_pop);
  assign w_drop  = r_en_d2 && w_full && !w_pop;

  // Upstream data lags its enable by two edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_d1 <= 1'b0;
      r_en_d2 <= 1'b0;
    end else if (i_clr) begin
      r_en_d1 <= 1'b0;
      r_en_d2 <= 1'b0;
    end else begin
      r_en_d1 <= i_en_tap;
      r_en_d2 <= r_en_d1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage is deliberately left out of reset and flush.
  always_ff @(posedge clk) begin
    if (w_push && !i_clr) r_mem[r_wr_ptr[AW-1:0]] <= w_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else if (i_clr) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

`ifdef PIPE_DRAIN_CKSUM_EN
  logic [31:0] r_cksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cksum <= 32'h0000_0000;
    end else if (i_clr) begin
      r_cksum <= 32'h0000_0000;
    end else if (w_push) begin
      r_cksum <= r_cksum ^ w_word;
    end
  end

  assign o_cksum = r_cksum;
`else
  assign o_cksum = 32'h0000_0000;
`endif

  assign o_data     = r_mem[r_rd_ptr[AW-1:0]];
  assign o_vld      = !w_empty;
  assign o_level    = r_wr_ptr - r_rd_ptr;
  assign o_ovf      = r_ovf;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: doc/pipe_drain.md
# pipe_drain

Output collector that sits directly downstream of the scaling pipe stage. It consumes that stage's registered `o_data0`/`o_data1` pair. It regenerates the pair's validity by delaying a tap of the stage's `i_en`, then buffers each valid pair as a 32-bit word in a FIFO and presents it on a valid/ready port. It also tracks overflow and, optionally, a running checksum.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `clk` in 1, single clock, all logic on posedge
- `rst_n` in 1, reset is asynchronous and active-low
- `i_clr` in 1, synchronous flush, active high
- `i_en_tap` in 1, copy of the upstream stage's `i_en`, same cycle as that stage sees it
- `i_data0` in 16, connected to upstream `o_data0`
- `i_data1` in 16, connected to upstream `o_data1`
- `o_data` out 32, head word `{data1, data0}`
- `o_vld` out 1, FIFO non-empty
- `i_rdy` in 1, consumer accepts head word
- `o_level` out $clog2(DEPTH)+1, current occupancy
- `o_ovf` out 1, sticky: a valid pair was dropped
- `o_drop_cnt` out 8, dropped-pair count, saturating
- `o_cksum` out 32, running XOR of accepted words (see Configuration)

## Operation
- **Validity alignment.**
  - 2-stage shift register: `en_d1 <= i_en_tap`, `en_d2 <= en_d1`.
  - Upstream data sampled at edge k (i_en high) appears on `i_data*` after edge k+1.
  - Capture occurs at edge k+2 when `en_d2`=1.
- **Push.** When `en_d2`=1, write `{i_data1, i_data0}` at `wr_ptr`.
  - Accepted if not full, or if full and a pop occurs in the same cycle.
- **Pop.** Occurs when `o_vld && i_rdy`; `rd_ptr` advances.
  - `i_rdy` while empty has no effect.
- **Output data.** `o_data` is a combinational read of `mem[rd_ptr]` (first-word fall-through).
  - `o_data` is undefined when `o_vld`=0; benches must not check it then.
- **Pointers.** Pointers are $clog2(DEPTH)+1 bits and wrap naturally.
  - full = MSBs differ and LSBs are equal.
  - empty = pointers are equal.
  - `o_level` = `wr_ptr - rd_ptr`.
- **Overflow.** A push while full with no same-cycle pop:
  - drops the word;
  - sets `o_ovf`;
  - increments `o_drop_cnt`, which saturates at 255.
- **Simultaneous push and pop.**
  - Both take effect.
  - Level is unchanged.
  - Allowed at full and at any non-empty level.
- **Flush (`i_clr`=1).** Has priority over push and pop. At the next edge it clears:
  - pointers, level, `en_d1`/`en_d2`;
  - `o_ovf`, `o_drop_cnt`, `o_cksum`.
  - FIFO memory contents are not cleared.
  - Pairs in flight in upstream when `i_clr` asserts are discarded.
- **Reset (async).** Clears the same state as flush, immediately.
  - Reset during operation discards all buffered words.
  - FIFO memory is not reset.

## Timing
- Reset values: `o_vld`=0, `o_level`=0, `o_ovf`=0, `o_drop_cnt`=0, `o_cksum`=0; `o_data` is X/don't-care.
- Latency: `i_en_tap` high in the cycle before edge k → `o_vld`=1 after edge k+2, assuming the FIFO was empty.
- Throughput: one push and one pop per cycle sustained.
- `o_vld`, `o_level`, `o_ovf` and `o_drop_cnt` are registered-state derived; they have no combinational path from `i_rdy`.
- `i_rdy` may be held high while `o_vld` is low.
- A word is transferred on every edge where `o_vld && i_rdy`.

## Configuration
- Macro: `PIPE_DRAIN_CKSUM_EN`.
- **Defined:**
  - `o_cksum <= o_cksum ^ word` on every accepted push.
  - Dropped words are excluded.
  - Cleared by reset and by `i_clr`.
- **Undefined:**
  - The checksum register is not built.
  - `o_cksum` is tied to 32'h0000_0000.
  - Port list is unchanged.

## Test plan
- **Latency and order.**
  - After reset, `i_en_tap`=1 for 3 cycles; upstream outputs `{0x0002,0x0001}`, `{0x0004,0x0003}`, `{0x0006,0x0005}` on successive cycles; `i_rdy`=1.
  - Required: `o_vld` rises 2 edges after the first enable; words 0x00020001, 0x00040003, 0x00060005 appear in order; `o_level` stays ≤1.
- **Fill, overflow and drop saturation.**
  - `i_rdy`=0; 8 valid pairs → `o_level`=8, `o_ovf`=0.
  - 2 more pairs → `o_ovf`=1, `o_drop_cnt`=2, first 8 words intact on drain.
  - 300 further drops → `o_drop_cnt`=255.
- **Simultaneous push and pop at full.**
  - FIFO full and `i_rdy`=1 while a pair is captured.
  - Required: `o_level` stays 8, `o_ovf` stays 0, new word emerges 8th after.
- **Flush.**
  - 5 words buffered, one pair in the alignment pipe; pulse `i_clr`.
  - Required: `o_vld`=0, `o_level`=0, `o_ovf`=0 next cycle; the in-flight pair is never output.
- **Async reset mid-stream.**
  - Assert `rst_n`=0 between edges with 3 words buffered.
  - Required: `o_vld`=0 and `o_level`=0 immediately, without waiting for a clock edge; operation resumes correctly after release.
- **Checksum.** With `PIPE_DRAIN_CKSUM_EN` defined, push 0x12345678, 0xFFFF0000, 0x0000FFFF, plus one dropped word.
  - Required: `o_cksum`=0xEDCBA987; the dropped word is excluded.
  - Without the macro, `o_cksum`=0 throughout.
